ram_bank_sequencer: RTL and testbench
=====================================

# ram_bank_sequencer

Frame-level controller for the two-bank RAM demux subsystem. It accepts frame commands (word count N) and drives the demux select channel so that each frame lands in the next bank (0, 1, 0, …). It grants the write port to the producer until N writes complete, then grants the read port to the consumer until N reads complete, and reports the finished bank. It sits beside the demux. It owns the `sel_req`/`sel_resp` channel exclusively and only observes completed write and read responses.

## Interface
Parameters:
- SIZE, 1024, words per bank.
- ADDR_WIDTH, $clog2(SIZE), bank address width; counts use CNT_W = ADDR_WIDTH+1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- frame_req_r_data  in  CNT_W  frame word count N.
- frame_req_r_vld  in  1  frame command valid.
- frame_req_r_rdy  out  1  frame command accepted.
- sel_req_s_data  out  1  bank select sent to the demux.
- sel_req_s_vld  out  1  select request valid.
- sel_req_s_rdy  in  1  demux accepts the select.
- sel_resp_r_vld  in  1  demux select acknowledge.
- sel_resp_r_rdy  out  1  acknowledge accepted.
- wr_cmpl  in  1  one-cycle pulse per completed write (`wr_resp` handshake).
- rd_cmpl  in  1  one-cycle pulse per completed read (`rd_resp` handshake).
- wr_grant  out  1  producer may issue writes.
- rd_grant  out  1  consumer may issue reads.
- frame_done_s_data  out  1  bank that held the finished frame.
- frame_done_s_vld  out  1  frame finished.
- frame_done_s_rdy  in  1  completion accepted.
- bank  out  1  bank of the current or most recent frame.
- err  out  1  sticky protocol error flag.

## Operation
- FSM states: IDLE, SEL, SEL_WAIT, FILL, DRAIN, DONE. All outputs are decoded from registered state and registers only; no input-to-output combinational paths.
- IDLE:
  - frame_req_r_rdy=1.
  - On a frame_req handshake with 1≤N≤SIZE: latch N, set bank ← next_bank, go to SEL.
  - On a handshake with N=0 or N>SIZE: set err=1, consume the command, stay in IDLE; bank and next_bank unchanged.
- SEL: sel_req_s_vld=1, sel_req_s_data=bank. Hold both stable until sel_req_s_rdy, then go to SEL_WAIT.
- SEL_WAIT: sel_resp_r_rdy=1. On sel_resp_r_vld, go to FILL.
- FILL:
  - wr_grant=1.
  - Counter cnt (CNT_W) increments on each wr_cmpl.
  - When wr_cmpl arrives with cnt==N-1: cnt←0, go to DRAIN.
- DRAIN:
  - rd_grant=1.
  - cnt increments on each rd_cmpl.
  - When rd_cmpl arrives with cnt==N-1: cnt←0, go to DONE.
- DONE: frame_done_s_vld=1, frame_done_s_data=bank. On frame_done_s_rdy: next_bank←~bank, go to IDLE.
- next_bank resets to 0, so the first frame uses bank 0 and banks alternate per completed frame.
- Protocol errors set err=1; the pulse is otherwise ignored and does not count:
  - wr_cmpl outside FILL.
  - rd_cmpl outside DRAIN.
  - sel_resp_r_vld outside SEL_WAIT.
- err clears only on reset.
- wr_grant and rd_grant are never both 1.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE; cnt=0; N=0; bank=0; next_bank=0; err=0.
  - Outputs: frame_req_r_rdy=1 after reset release, all other outputs 0.
- Reset mid-frame: abandons the frame immediately. Grants drop asynchronously, and no frame_done is produced.
- Latency from frame_req handshake:
  - sel_req_s_vld rises the next cycle.
  - FILL entered 1 cycle after the sel_resp handshake.
  - rd_grant rises the cycle after the Nth wr_cmpl; wr_grant falls the same cycle.
  - frame_done_s_vld rises the cycle after the Nth rd_cmpl.
- Minimum frame with N=1, all ready/valid/pulses immediate: 6 cycles from IDLE back to IDLE.
- N=SIZE: cnt reaches SIZE-1 without overflow; CNT_W holds SIZE.
- wr_cmpl on the cycle FILL→DRAIN transitions: counted in FILL. An rd_cmpl in that same cycle flags err.
- frame_req_r_vld while busy: held off (rdy=0); no loss.

## Test plan
- Reset, then N=4, immediate handshakes:
  - sel_req_s_data=0.
  - wr_grant high for exactly 4 wr_cmpl, then rd_grant for 4 rd_cmpl.
  - frame_done_s_data=0; err=0.
- Three back-to-back frames N=2, 1, 3 → select data 0, 1, 0; frame_done banks 0, 1, 0; bank toggles only on a frame_done handshake.
- Backpressure:
  - sel_req_s_rdy low 5 cycles → sel_req_s_vld and data stay stable.
  - frame_done_s_rdy low 3 cycles → vld held, next frame_req not accepted until done accepted.
- N=0, then N=SIZE+1 → both consumed; err=1; no sel_req; next valid frame still uses bank 0.
- Spurious pulses: wr_cmpl in IDLE and rd_cmpl during FILL → err=1; FILL count unaffected (still needs N wr_cmpl).
- Assert rst low in DRAIN after 2 of 4 reads → all outputs 0 immediately; after release, bank=0, err=0, frame_req_r_rdy=1.

Source files
------------

// File: rtl/ram_bank_sequencer.sv
// Frame-level controller for the two-bank RAM demux: selects the bank for each frame,
// grants the write port until N writes land, then the read port until N reads drain.
module ram_bank_sequencer #(
    parameter int unsigned SIZE       = 1024,
    parameter int unsigned ADDR_WIDTH = $clog2(SIZE),
    localparam int unsigned CNT_W     = ADDR_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [CNT_W-1:0] frame_req_r_data,
    input  logic             frame_req_r_vld,
    output logic             frame_req_r_rdy,

    output logic             sel_req_s_data,
    output logic             sel_req_s_vld,
    input  logic             sel_req_s_rdy,

    input  logic             sel_resp_r_vld,
    output logic             sel_resp_r_rdy,

    input  logic             wr_cmpl,
    input  logic             rd_cmpl,
    output logic             wr_grant,
    output logic             rd_grant,

    output logic             frame_done_s_data,
    output logic             frame_done_s_vld,
    input  logic             frame_done_s_rdy,

    output logic             bank,
    output logic             err
);

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StSelWait,
        StFill,
        StDrain,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             bank_q, bank_d;
    logic             next_bank_q, next_bank_d;
    logic             err_q, err_d;
    // Keeps frame_req_r_rdy low while reset is asserted; rises on the first clock after release.
    logic             out_en_q;

    logic             req_accept;
    logic             n_ok;
    logic             last_beat;

    assign req_accept = frame_req_r_vld & frame_req_r_rdy;
    assign n_ok       = (frame_req_r_data != '0) && (frame_req_r_data <= CNT_W'(SIZE));
    assign last_beat  = (cnt_q == n_q - CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            n_q         <= '0;
            bank_q      <= 1'b0;
            next_bank_q <= 1'b0;
            err_q       <= 1'b0;
            out_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            bank_q      <= bank_d;
            next_bank_q <= next_bank_d;
            err_q       <= err_d;
            out_en_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        bank_d      = bank_q;
        next_bank_d = next_bank_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_accept) begin
                    if (n_ok) begin
                        n_d     = frame_req_r_data;
                        bank_d  = next_bank_q;
                        state_d = StSel;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StSel: begin
                if (sel_req_s_rdy) begin
                    state_d = StSelWait;
                end
            end
            StSelWait: begin
                if (sel_resp_r_vld) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (wr_cmpl) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDrain: begin
                if (rd_cmpl) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDone: begin
                if (frame_done_s_rdy) begin
                    next_bank_d = ~bank_q;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Out-of-phase pulses are not counted, only flagged.
        if (wr_cmpl && (state_q != StFill)) begin
            err_d = 1'b1;
        end
        if (rd_cmpl && (state_q != StDrain)) begin
            err_d = 1'b1;
        end
        if (sel_resp_r_vld && (state_q != StSelWait)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        frame_req_r_rdy   = out_en_q && (state_q == StIdle);
        sel_req_s_vld     = (state_q == StSel);
        sel_req_s_data    = (state_q == StSel) ? bank_q : 1'b0;
        sel_resp_r_rdy    = (state_q == StSelWait);
        wr_grant          = (state_q == StFill);
        rd_grant          = (state_q == StDrain);
        frame_done_s_vld  = (state_q == StDone);
        frame_done_s_data = (state_q == StDone) ? bank_q : 1'b0;
        bank              = bank_q;
        err               = err_q;
    end

endmodule

// File: tb/tb_ram_bank_sequencer.sv
// Scoreboard bench for ram_bank_sequencer: expected banks are queued at frame acceptance and
// compared when the select and frame_done handshakes occur.
module tb_ram_bank_sequencer;

    localparam int unsigned SIZE  = 16;
    localparam int unsigned CNT_W = $clog2(SIZE) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] frame_req_r_data;
    logic             frame_req_r_vld;
    logic             frame_req_r_rdy;
    logic             sel_req_s_data;
    logic             sel_req_s_vld;
    logic             sel_req_s_rdy;
    logic             sel_resp_r_vld;
    logic             sel_resp_r_rdy;
    logic             wr_cmpl;
    logic             rd_cmpl;
    logic             wr_grant;
    logic             rd_grant;
    logic             frame_done_s_data;
    logic             frame_done_s_vld;
    logic             frame_done_s_rdy;
    logic             bank;
    logic             err;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    logic exp_next;
    logic sel_q[$];
    logic done_q[$];

    always #5 clk = ~clk;

    ram_bank_sequencer #(
        .SIZE(SIZE)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_req_r_data (frame_req_r_data),
        .frame_req_r_vld  (frame_req_r_vld),
        .frame_req_r_rdy  (frame_req_r_rdy),
        .sel_req_s_data   (sel_req_s_data),
        .sel_req_s_vld    (sel_req_s_vld),
        .sel_req_s_rdy    (sel_req_s_rdy),
        .sel_resp_r_vld   (sel_resp_r_vld),
        .sel_resp_r_rdy   (sel_resp_r_rdy),
        .wr_cmpl          (wr_cmpl),
        .rd_cmpl          (rd_cmpl),
        .wr_grant         (wr_grant),
        .rd_grant         (rd_grant),
        .frame_done_s_data(frame_done_s_data),
        .frame_done_s_vld (frame_done_s_vld),
        .frame_done_s_rdy (frame_done_s_rdy),
        .bank             (bank),
        .err              (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_req_rdy"}, frame_req_r_rdy, 0);
        check({tag, "_sel_vld"}, sel_req_s_vld, 0);
        check({tag, "_sel_data"}, sel_req_s_data, 0);
        check({tag, "_resp_rdy"}, sel_resp_r_rdy, 0);
        check({tag, "_wr_grant"}, wr_grant, 0);
        check({tag, "_rd_grant"}, rd_grant, 0);
        check({tag, "_done_vld"}, frame_done_s_vld, 0);
        check({tag, "_done_data"}, frame_done_s_data, 0);
        check({tag, "_bank"}, bank, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Asserts reset away from the clock edge and checks the asynchronous effect at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_low(tag);
        exp_next = 1'b0;
        sel_q.delete();
        done_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_rel_req_rdy"}, frame_req_r_rdy, 1);
        check({tag, "_rel_bank"}, bank, 0);
        check({tag, "_rel_err"}, err, 0);
    endtask

    // Entered at a negedge with the DUT idle; leaves it in FILL.
    task automatic start_frame(input int unsigned n, input int unsigned sel_stall);
        logic got;
        check("req_rdy_idle", frame_req_r_rdy, 1);
        frame_req_r_data = CNT_W'(n);
        frame_req_r_vld  = 1'b1;
        sel_q.push_back(exp_next);
        done_q.push_back(exp_next);
        @(negedge clk);
        frame_req_r_vld = 1'b0;
        check("sel_vld", sel_req_s_vld, 1);
        check("sel_data", sel_req_s_data, sel_q[0]);
        check("bank_frame", bank, sel_q[0]);
        check("req_rdy_busy", frame_req_r_rdy, 0);
        for (int i = 0; i < int'(sel_stall); i++) begin
            @(negedge clk);
            check("sel_vld_stall", sel_req_s_vld, 1);
            check("sel_data_stall", sel_req_s_data, sel_q[0]);
        end
        sel_req_s_rdy = 1'b1;
        got = sel_req_s_data;
        @(negedge clk);
        sel_req_s_rdy = 1'b0;
        check("sel_bank_hs", got, sel_q.pop_front());
        check("sel_vld_after", sel_req_s_vld, 0);
        check("resp_rdy", sel_resp_r_rdy, 1);
        check("wr_grant_selwait", wr_grant, 0);
        sel_resp_r_vld = 1'b1;
        @(negedge clk);
        sel_resp_r_vld = 1'b0;
    endtask

    task automatic fill(input int unsigned n, input bit spurious_rd);
        if (spurious_rd) begin
            rd_cmpl = 1'b1;
            @(negedge clk);
            rd_cmpl = 1'b0;
            check("err_spur_rd", err, 1);
        end
        for (int i = 0; i < int'(n); i++) begin
            check("wr_grant_fill", wr_grant, 1);
            check("rd_grant_fill", rd_grant, 0);
            wr_cmpl = 1'b1;
            @(negedge clk);
            wr_cmpl = 1'b0;
        end
        check("wr_grant_drain", wr_grant, 0);
        check("rd_grant_drain", rd_grant, 1);
    endtask

    task automatic drain(input int unsigned n, input bit full);
        for (int i = 0; i < int'(n); i++) begin
            check("rd_grant_beat", rd_grant, 1);
            rd_cmpl = 1'b1;
            @(negedge clk);
            rd_cmpl = 1'b0;
        end
        if (full) begin
            check("rd_grant_done", rd_grant, 0);
            check("done_vld", frame_done_s_vld, 1);
        end
    endtask

    task automatic finish_frame(input int unsigned done_stall);
        logic got;
        check("done_data", frame_done_s_data, done_q[0]);
        for (int i = 0; i < int'(done_stall); i++) begin
            frame_req_r_data = CNT_W'(1);
            frame_req_r_vld  = 1'b1;
            check("req_held_off", frame_req_r_rdy, 0);
            @(negedge clk);
            check("done_vld_stall", frame_done_s_vld, 1);
            check("done_data_stall", frame_done_s_data, done_q[0]);
        end
        frame_req_r_vld  = 1'b0;
        frame_done_s_rdy = 1'b1;
        got = frame_done_s_data;
        @(negedge clk);
        frame_done_s_rdy = 1'b0;
        check("done_bank_hs", got, done_q.pop_front());
        check("done_vld_after", frame_done_s_vld, 0);
        check("req_rdy_after", frame_req_r_rdy, 1);
        check("bank_hold_idle", bank, got);
        exp_next = ~exp_next;
    endtask

    task automatic full_frame(input int unsigned n, input int unsigned sel_stall,
                              input int unsigned done_stall);
        start_frame(n, sel_stall);
        fill(n, 1'b0);
        drain(n, 1'b1);
        finish_frame(done_stall);
    endtask

    initial begin
        rst              = 1'b0;
        frame_req_r_data = '0;
        frame_req_r_vld  = 1'b0;
        sel_req_s_rdy    = 1'b0;
        sel_resp_r_vld   = 1'b0;
        wr_cmpl          = 1'b0;
        rd_cmpl          = 1'b0;
        frame_done_s_rdy = 1'b0;
        exp_next         = 1'b0;

        #1;
        check_all_low("por");
        do_reset("rst0");

        // Basic frame, then three back-to-back frames alternating banks.
        full_frame(4, 0, 0);
        check("err_basic", err, 0);
        do_reset("rst1");
        full_frame(2, 0, 0);
        full_frame(1, 0, 0);
        full_frame(3, 0, 0);
        check("err_b2b", err, 0);

        // Backpressure on select and completion, then a full-size frame.
        full_frame(2, 5, 3);
        full_frame(SIZE, 0, 0);
        check("err_bp", err, 0);

        // Illegal word counts are consumed and flagged without touching the bank sequence.
        do_reset("rst2");
        frame_req_r_data = '0;
        frame_req_r_vld  = 1'b1;
        @(negedge clk);
        frame_req_r_vld = 1'b0;
        check("err_n0", err, 1);
        check("sel_vld_n0", sel_req_s_vld, 0);
        check("req_rdy_n0", frame_req_r_rdy, 1);
        frame_req_r_data = CNT_W'(SIZE + 1);
        frame_req_r_vld  = 1'b1;
        @(negedge clk);
        frame_req_r_vld = 1'b0;
        check("sel_vld_nbig", sel_req_s_vld, 0);
        check("req_rdy_nbig", frame_req_r_rdy, 1);
        check("bank_nbig", bank, 0);
        full_frame(2, 0, 0);
        check("err_sticky", err, 1);

        // Spurious completions do not advance the fill count.
        do_reset("rst3");
        wr_cmpl = 1'b1;
        @(negedge clk);
        wr_cmpl = 1'b0;
        check("err_spur_wr", err, 1);
        check("req_rdy_spur", frame_req_r_rdy, 1);
        start_frame(3, 0);
        fill(3, 1'b1);
        drain(3, 1'b1);
        finish_frame(0);

        // Reset in the middle of draining a bank-1 frame.
        do_reset("rst4");
        full_frame(1, 0, 0);
        start_frame(4, 0);
        fill(4, 1'b0);
        drain(2, 1'b0);
        check("rd_grant_mid", rd_grant, 1);
        check("bank_mid", bank, 1);
        do_reset("rst_mid");
        full_frame(1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
